// File: rtl/ex_forward_ctrl.sv
// EX-stage forwarding and hazard controller for a 5-stage RISC-V pipeline.
// Tracks in-flight destination tags, registers operand forwarding selects and stalls ID on uncoverable hazards.
module ex_forward_ctrl #(
  parameter int REG_AW   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              flush,
  output logic              stall,
  output logic              ex_bubble,
  output logic              ex_valid,
  output logic [1:0]        SelFwA,
  output logic [1:0]        SelFwB,
  output logic              SelFwWD
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              memread;
  } tag_t;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  // A producer that has left WB is already visible through the register file
  // read in ID, so no retired tag is needed to form any select.
  tag_t       r_ex_t, r_mem_t, r_wb_t;
  logic [0:0] r_state;
  logic       r_ex_valid;
  logic [1:0] r_sel_a, r_sel_b;
  logic       r_sel_wd;

  function automatic logic f_match(input tag_t t, input logic [REG_AW-1:0] r);
    return t.valid && t.regwrite && (t.rd == r) && (r != '0) && (int'(r) < NUM_REGS);
  endfunction

  function automatic logic [1:0] f_sel(input logic use_r, input logic [REG_AW-1:0] r,
                                       input tag_t ex_t, input tag_t mem_t, input tag_t wb_t);
    if (!use_r)                return 2'd0;
    else if (f_match(ex_t, r))  return 2'd1;
    else if (f_match(mem_t, r)) return 2'd2;
    else if (f_match(wb_t, r))  return 2'd3;
    else                        return 2'd0;
  endfunction

  logic       w_st_ex, w_st_mem, w_st_wb, w_load_use;
  logic [1:0] w_need;
  logic       w_stall, w_issue;
  logic [0:0] w_next_state;
  logic [1:0] w_sel_a, w_sel_b;
  tag_t       w_id_tag;

  assign w_st_ex    = id_memwrite && f_match(r_ex_t,  id_rs2);
  assign w_st_mem   = id_memwrite && f_match(r_mem_t, id_rs2);
  assign w_st_wb    = id_memwrite && f_match(r_wb_t,  id_rs2);
  assign w_load_use = r_ex_t.memread &&
                      ((id_use_rs1 && f_match(r_ex_t, id_rs1)) ||
                       (id_use_rs2 && f_match(r_ex_t, id_rs2)));

  // Hazards overlap in time, so only the largest requirement is applied.
  assign w_need = w_st_ex ? 2'd2 : ((w_st_mem || w_load_use) ? 2'd1 : 2'd0);

  assign w_sel_a  = f_sel(id_use_rs1, id_rs1, r_ex_t, r_mem_t, r_wb_t);
  assign w_sel_b  = f_sel(id_use_rs2, id_rs2, r_ex_t, r_mem_t, r_wb_t);
  assign w_id_tag = '{valid: 1'b1, rd: id_rd, regwrite: id_regwrite, memread: id_memread};

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_stall      = 1'b0;
    w_next_state = r_state;
    case (r_state)
      ST_RUN: begin
        w_stall = id_valid && (w_need != 2'd0) && !flush;
        if (w_stall && (w_need == 2'd2)) w_next_state = ST_HOLD;
      end
      default: begin
        w_stall      = !flush;
        w_next_state = ST_RUN;
      end
    endcase
  end

  assign w_issue   = id_valid && !w_stall && !flush;
  assign stall     = w_stall;
  assign ex_bubble = rst_n && !w_issue;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_RUN;
      r_ex_t     <= '0;
      r_mem_t    <= '0;
      r_wb_t     <= '0;
      r_ex_valid <= 1'b0;
      r_sel_a    <= 2'd0;
      r_sel_b    <= 2'd0;
      r_sel_wd   <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_wb_t     <= r_mem_t;
      r_mem_t    <= r_ex_t;
      r_ex_t     <= w_issue ? w_id_tag : '0;
      r_ex_valid <= w_issue;
      r_sel_a    <= w_issue ? w_sel_a : 2'd0;
      r_sel_b    <= w_issue ? w_sel_b : 2'd0;
      r_sel_wd   <= w_issue && w_st_wb;
    end
  end

  assign ex_valid = r_ex_valid;
  assign SelFwA   = r_sel_a;
  assign SelFwB   = r_sel_b;
  assign SelFwWD  = r_sel_wd;

endmodule

// File: tb/tb_ex_forward_ctrl.sv
// Directed bench for ex_forward_ctrl: forwarding distances, load-use and store stalls, flush and reset.
module tb_ex_forward_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_use_rs1, id_use_rs2, id_regwrite, id_memread, id_memwrite, flush;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       stall, ex_bubble, ex_valid, SelFwWD;
  logic [1:0] SelFwA, SelFwB;

  int n_checks = 0;
  int n_errors = 0;

  ex_forward_ctrl #(.REG_AW(5), .NUM_REGS(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_memwrite(id_memwrite), .flush(flush),
    .stall(stall), .ex_bubble(ex_bubble), .ex_valid(ex_valid),
    .SelFwA(SelFwA), .SelFwB(SelFwB), .SelFwWD(SelFwWD)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one ID-stage instruction: valid, rs1, rs2, rd, use1, use2, regwrite, memread, memwrite.
  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic u1, input logic u2, input logic rw, input logic mr, input logic mw);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_use_rs1 = u1; id_use_rs2 = u2; id_regwrite = rw; id_memread = mr; id_memwrite = mw;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic nop();
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
  endtask

  initial begin
    flush = 1'b0;
    rst_n = 1'b0;
    drive(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("reset_stall", stall, 0);
    check("reset_bubble", ex_bubble, 0);
    check("reset_ex_valid", ex_valid, 0);
    check("reset_sel_a", SelFwA, 0);
    check("reset_sel_b", SelFwB, 0);
    check("reset_sel_wd", SelFwWD, 0);
    rst_n = 1'b1;
    idle(4);

    // Back-to-back ALU: add x5,x1,x2 ; sub x6,x5,x7
    drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("b2b_prod_stall", stall, 0);
    tick();
    drive(1'b1, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("b2b_stall", stall, 0);
    check("b2b_bubble", ex_bubble, 0);
    tick();
    check("b2b_ex_valid", ex_valid, 1);
    check("b2b_sel_a", SelFwA, 1);
    check("b2b_sel_b", SelFwB, 0);
    idle(4);

    // Distance 2: add x5 ; nop ; add x8,x5,x5
    drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    nop();
    drive(1'b1, 5'd5, 5'd5, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("d2_stall", stall, 0);
    tick();
    check("d2_sel_a", SelFwA, 2);
    check("d2_sel_b", SelFwB, 2);
    idle(4);

    // Distance 3: add x5 ; nop ; nop ; add x8,x5,x5
    drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    nop();
    nop();
    drive(1'b1, 5'd5, 5'd5, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    check("d3_sel_a", SelFwA, 3);
    check("d3_sel_b", SelFwB, 3);
    idle(4);

    // Producer writing x0 never forwards: add x0 ; add x8,x0,x0
    drive(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b1, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    check("x0_sel_a", SelFwA, 0);
    check("x0_sel_b", SelFwB, 0);
    // Load to x0 followed by a use of x0 never stalls
    drive(1'b1, 5'd2, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0); tick();
    drive(1'b1, 5'd0, 5'd0, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("x0_load_stall", stall, 0);
    idle(4);

    // Load-use: ld x5,0(x2) ; add x6,x5,x1
    drive(1'b1, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0); tick();
    drive(1'b1, 5'd5, 5'd1, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("lu_stall", stall, 1);
    check("lu_bubble", ex_bubble, 1);
    tick();
    check("lu_ex_valid_bubble", ex_valid, 0);
    check("lu_sel_a_bubble", SelFwA, 0);
    check("lu_stall_released", stall, 0);
    check("lu_bubble_released", ex_bubble, 0);
    tick();
    check("lu_ex_valid", ex_valid, 1);
    check("lu_sel_a", SelFwA, 2);
    check("lu_sel_b", SelFwB, 0);
    idle(4);

    // Store data distance 1: add x9 ; sd x9,0(x2) -> two stalls then SelFwWD=1
    drive(1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b1, 5'd2, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("st1_stall_c1", stall, 1);
    tick();
    check("st1_stall_c2", stall, 1);
    check("st1_bubble_c2", ex_bubble, 1);
    tick();
    check("st1_stall_c3", stall, 0);
    tick();
    check("st1_ex_valid", ex_valid, 1);
    check("st1_sel_wd", SelFwWD, 1);
    check("st1_sel_a", SelFwA, 0);
    idle(4);

    // Store data distance 2: add x9 ; nop ; sd x9 -> one stall then SelFwWD=1
    drive(1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    nop();
    drive(1'b1, 5'd2, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("st2_stall_c1", stall, 1);
    tick();
    check("st2_stall_c2", stall, 0);
    tick();
    check("st2_sel_wd", SelFwWD, 1);
    idle(4);

    // Store with no producer match
    drive(1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b1, 5'd2, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("st0_stall", stall, 0);
    tick();
    check("st0_sel_wd", SelFwWD, 0);
    check("st0_ex_valid", ex_valid, 1);
    idle(4);

    // Load-use and store hazard together: ld x9 ; sd x9,0(x9) -> max(1,2)=2 stalls, not 3
    drive(1'b1, 5'd2, 5'd0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0); tick();
    drive(1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("mix_stall_c1", stall, 1);
    tick();
    check("mix_stall_c2", stall, 1);
    tick();
    check("mix_stall_c3", stall, 0);
    tick();
    check("mix_sel_a", SelFwA, 3);
    check("mix_sel_wd", SelFwWD, 1);
    idle(4);

    // Flush during HOLD
    drive(1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b1, 5'd2, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check("fl_hold_stall", stall, 1);
    flush = 1'b1; #1;
    check("fl_stall_released", stall, 0);
    check("fl_bubble", ex_bubble, 1);
    tick();
    flush = 1'b0;
    check("fl_ex_valid", ex_valid, 0);
    drive(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("fl_run_stall", stall, 0);
    tick();
    check("fl_next_ex_valid", ex_valid, 1);
    check("fl_next_sel_a", SelFwA, 0);
    idle(4);

    // Reset pulsed mid-stall
    drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b1, 5'd5, 5'd5, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    check("rs_pre_sel_a", SelFwA, 1);
    drive(1'b1, 5'd2, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("rs_pre_stall", stall, 1);
    rst_n = 1'b0; #1;
    check("rs_stall", stall, 0);
    check("rs_bubble", ex_bubble, 0);
    check("rs_ex_valid", ex_valid, 0);
    check("rs_sel_a", SelFwA, 0);
    check("rs_sel_b", SelFwB, 0);
    check("rs_sel_wd", SelFwWD, 0);
    @(negedge clk);
    rst_n = 1'b1; #1;
    check("rs_after_stall", stall, 0);
    tick();
    check("rs_after_ex_valid", ex_valid, 1);
    check("rs_after_sel_a", SelFwA, 0);
    check("rs_after_sel_wd", SelFwWD, 0);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ex_forward_ctrl.md
Name: ex_forward_ctrl

Overview:
- Forwarding and hazard controller for the EX stage of the 5-stage RISC-V pipeline.
- Tracks destination-register tags of in-flight instructions (EX, MEM, WB, retired) and registers the forwarding selects for the instruction entering EX: SelFwA, SelFwB and SelFwWD.
- Stalls IF/ID and injects EX bubbles for load-use and store-data hazards that the forwarding network cannot cover.

Parameters:
REG_AW, 5, register index width
NUM_REGS, 32, architectural register count; index 0 hardwired zero

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  valid instruction in ID
id_rs1  in  REG_AW  source 1 index
id_rs2  in  REG_AW  source 2 index
id_rd  in  REG_AW  destination index
id_use_rs1  in  1  ALU operand A reads rs1
id_use_rs2  in  1  ALU operand B reads rs2 (0 when ALUScr selects Imm)
id_regwrite  in  1  instruction writes rd
id_memread  in  1  load
id_memwrite  in  1  store (rs2 is store data)
flush  in  1  kill instruction in ID (branch taken in EX)
stall  out  1  hold PC and IF/ID register
ex_bubble  out  1  EX register loads a NOP this cycle
ex_valid  out  1  registered: EX holds a real instruction
SelFwA  out  2  registered: 0 data1, 1 Fw1 (EX/MEM), 2 Fw2 (MEM/WB), 3 Fw3 (retired value)
SelFwB  out  2  same encoding for operand B
SelFwWD  out  1  registered: 0 data2, 1 FwWD (retired value)

Behaviour:
- Reset (async, rst_n=0): FSM=RUN; all tags invalid; stall=0, ex_bubble=0, ex_valid=0, SelFwA=0, SelFwB=0, SelFwWD=0.
- Tags: ex_t, mem_t, wb_t, ret_t. Each tag is {valid, rd, regwrite, memread}.
- Tags shift every clock: ret_t<=wb_t, wb_t<=mem_t, mem_t<=ex_t.
- ex_t<=ID tag when issue=id_valid & !stall & !flush; otherwise ex_t<=invalid.
- ex_bubble = !issue.
- match(X,r) = X.valid & X.regwrite & X.rd==r & r!=0.
- Select computation (combinational from current tags, registered on issue), nearest producer wins:
  - ex_t → 1; mem_t → 2; wb_t → 3; none → 0.
  - SelFwA uses rs1, gated by id_use_rs1. SelFwB uses rs2, gated by id_use_rs2.
- On a bubble, all selects are registered as 0 and ex_valid=0.
- Store data (id_memwrite=1):
  - match(ex_t,rs2) → needs 2 stall cycles.
  - match(mem_t,rs2) → needs 1 stall cycle.
  - match(wb_t,rs2) → SelFwWD=1 at issue.
  - No match → SelFwWD=0.
- Load-use: id_use_rs1/rs2 matches ex_t with ex_t.memread=1 → needs 1 stall cycle.
- N = maximum stall requirement across all hazards, 0..2.
- FSM:
  - RUN: stall = id_valid & N>0 & !flush. If N==2 and stalling, go to HOLD; otherwise stay in RUN.
  - HOLD: stall=1 unconditionally; next state RUN.
  - Re-evaluation in RUN resolves any residual hazard on the following cycle.
- flush has priority over stall:
  - stall=0, bubble injected, FSM→RUN in the same cycle, including from HOLD.
- rd==0 producers are never forwarded and never stall.
- If both a load-use and a store hazard exist, only the maximum N is applied; stalls are not summed.
- Reset mid-stall: immediate return to the reset state, no residual stall.
- Fixed latency: selects are valid in the cycle the instruction occupies EX and are held for exactly one cycle.

Test Plan:
- Back-to-back ALU: add x5 then sub x6,x5,x7 → SelFwA=1 in the sub's EX cycle; no stall.
- Distance-2 and distance-3: add x5; nop; add x8,x5,x5 → SelFwA=SelFwB=2. With two nops in between → SelFwA=SelFwB=3. Producer writing x0 → selects 0.
- Load-use: ld x5; add x6,x5,x1 → stall=1 for one cycle with ex_bubble=1; the add then gets SelFwA=2.
- Store data: add x9; sd x9,0(x2) → stall for 2 cycles, then SelFwWD=1. With one nop in between → 1 stall cycle, then SelFwWD=1. Store with no match → SelFwWD=0.
- Flush during HOLD: stall released the same cycle; ex_valid=0 next cycle; FSM returns to RUN.
- rst_n pulsed low mid-stall → all outputs 0 asynchronously; the first instruction after reset gets selects 0.
